cpu_multicycle: RTL

- Parametrised multicycle CPU core: fetch/decode/execute/memory/writeback FSM, register file sized by NREGS, datapath sized by WIDTH.
- Single shared memory port with a req/ready handshake, so wait-states are supported.
- Explicit zero flag, branch, halt and illegal-opcode reporting.
- Sits between the system memory and the top level.

---
 rtl/cpu_multicycle_if.sv | 15 +
 rtl/cpu_multicycle.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_if.sv
// Shared memory port of cpu_multicycle: one req/ready channel used for both
// instruction fetch and data access.
interface cpu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] datao;
  logic [WIDTH-1:0] address;
  logic             rw;
  logic             mem_req;
  logic             mem_ready;

  modport master (input data, mem_ready, output datao, address, rw, mem_req);
  modport slave  (output data, mem_ready, input datao, address, rw, mem_req);
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer over a single
// shared memory port with wait-state support.
module cpu_multicycle #(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  cpu_multicycle_if.master bus,
  output logic             halted,
  output logic             illegal
);
  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_ADD  = 7'd1;
  localparam logic [6:0] OP_SUB  = 7'd2;
  localparam logic [6:0] OP_AND  = 7'd3;
  localparam logic [6:0] OP_OR   = 7'd4;
  localparam logic [6:0] OP_XOR  = 7'd5;
  localparam logic [6:0] OP_LDI  = 7'd6;
  localparam logic [6:0] OP_ST   = 7'd7;
  localparam logic [6:0] OP_LD   = 7'd8;
  localparam logic [6:0] OP_JMP  = 7'd9;
  localparam logic [6:0] OP_BZ   = 7'd10;
  localparam logic [6:0] OP_HALT = 7'd11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]        pc;
  logic [WIDTH-1:0]        op_a;
  logic [WIDTH-1:0]        op_b;
  logic [WIDTH-1:0]        result;
  logic [31:0]             instr;
  logic                    z;
  logic [WIDTH-1:0]        regs [NREGS];

  logic [6:0]              opcode;
  logic [RW-1:0]           rd;
  logic [RW-1:0]           ra;
  logic [RW-1:0]           rb;
  logic [15:0]             imm16;
  logic signed [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0]        alu_y;
  logic                    is_alu;
  logic                    is_st;
  logic                    unused_instr;

  // Register indices use only the low log2(NREGS) bits of each 4-bit field.
  assign opcode       = instr[6:0];
  assign rd           = instr[7 +: RW];
  assign ra           = instr[11 +: RW];
  assign rb           = instr[16 +: RW];
  assign imm16        = instr[31:16];
  assign imm_sx       = {{(WIDTH-16){imm16[15]}}, imm16};
  assign is_alu       = (opcode >= OP_ADD) && (opcode <= OP_XOR);
  assign is_st        = (opcode == OP_ST);
  assign unused_instr = ^instr;

  function automatic logic [WIDTH-1:0] alu(input logic [6:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      default: alu = a ^ b;
    endcase
  endfunction

  assign alu_y = alu(opcode, op_a, op_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    bus.mem_req = 1'b0;
    bus.rw      = 1'b0;
    bus.address = pc;
    bus.datao   = '0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (is_alu || opcode == OP_LDI)      state_n = S_WB;
        else if (opcode == OP_LD || is_st)   state_n = S_MEM;
        else if (opcode == OP_HALT)          state_n = S_HALT;
        else begin
          state_n = S_FETCH;
          illegal = (opcode > OP_HALT);
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.address = op_a;
        bus.rw      = is_st;
        bus.datao   = op_b;
        if (bus.mem_ready) state_n = is_st ? S_FETCH : S_WB;
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  halted  = 1'b1;
      default: state_n = S_FETCH;
    endcase
    // A transaction in flight is abandoned the moment reset rises.
    if (reset) bus.mem_req = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      z      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            instr <= bus.data[31:0];
            pc    <= pc + WIDTH'(1);
          end
        end
        S_DECODE: begin
          op_a <= regs[ra];
          op_b <= regs[rb];
        end
        S_EXEC: begin
          if (is_alu) begin
            result <= alu_y;
            z      <= (alu_y == '0);
          end else if (opcode == OP_LDI) begin
            result <= {{(WIDTH-16){1'b0}}, imm16};
          end else if (opcode == OP_JMP) begin
            pc <= op_a;
          end else if (opcode == OP_BZ && z) begin
            pc <= pc + $unsigned(imm_sx);
          end
        end
        S_MEM: begin
          if (bus.mem_ready && !is_st) result <= bus.data;
        end
        S_WB:    regs[rd] <= result;
        default: ;
      endcase
    end
  end
endmodule
